// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation-station bank.
package rs_pkg;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  localparam logic [TAG_W-1:0] NOT_REDIRECTED = '0;

  typedef enum logic [1:0] {
    FREE,
    WAITING,
    READY,
    EXECUTING
  } rs_state_t;

  // True when a valid CDB broadcast carries the tag held in the low bits of an operand field
  function automatic logic tag_hit(input logic valid, input logic [TAG_W-1:0] tag,
                                   input logic [DATA_W-1:0] field);
    return valid && (tag == field[TAG_W-1:0]);
  endfunction
endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB and dispatch signals of the reservation-station bank.
interface reservation_station_if import rs_pkg::*; #(parameter int OP_W = 4) ();
  logic              issue;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] A_value;
  logic [DATA_W-1:0] B_value;
  logic              A_invalid;
  logic              B_invalid;
  logic [TAG_W-1:0]  free_tag;
  logic              rs_full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              fu_valid;
  logic [OP_W-1:0]   fu_op;
  logic [DATA_W-1:0] fu_a;
  logic [DATA_W-1:0] fu_b;
  logic [TAG_W-1:0]  fu_tag;
  logic              fu_ready;

  // Upstream register file, CDB and functional unit side
  modport master (
    output issue, issue_op, A_value, B_value, A_invalid, B_invalid,
    output cdb_valid, cdb_tag, cdb_data, fu_ready,
    input  free_tag, rs_full, fu_valid, fu_op, fu_a, fu_b, fu_tag
  );

  // Reservation-station bank side
  modport slave (
    input  issue, issue_op, A_value, B_value, A_invalid, B_invalid,
    input  cdb_valid, cdb_tag, cdb_data, fu_ready,
    output free_tag, rs_full, fu_valid, fu_op, fu_a, fu_b, fu_tag
  );
endinterface

// File: rtl/rs_entry.sv
// One reservation station: state, operand capture with issue bypass, CDB snoop and release.
module rs_entry import rs_pkg::*; #(
  parameter int               OP_W    = 4,
  parameter logic [TAG_W-1:0] OWN_TAG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc,
  input  logic              accept,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] a_value,
  input  logic [DATA_W-1:0] b_value,
  input  logic              a_invalid,
  input  logic              b_invalid,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output rs_state_t         state,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b
);
  logic a_pend, b_pend;
  logic a_byp, b_byp, a_pend_in, b_pend_in;
  logic a_snoop, b_snoop;

  // Issue bypass and snoop matches; a pending operand keeps its tag in a/b low bits
  always_comb begin
    a_byp     = a_invalid && tag_hit(cdb_valid, cdb_tag, a_value);
    b_byp     = b_invalid && tag_hit(cdb_valid, cdb_tag, b_value);
    a_pend_in = a_invalid && !a_byp;
    b_pend_in = b_invalid && !b_byp;
    a_snoop   = a_pend && tag_hit(cdb_valid, cdb_tag, a);
    b_snoop   = b_pend && tag_hit(cdb_valid, cdb_tag, b);
  end

  // Entry lifecycle: FREE -> WAITING/READY -> EXECUTING -> FREE on own-tag broadcast
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FREE;
      op     <= '0;
      a      <= '0;
      b      <= '0;
      a_pend <= 1'b0;
      b_pend <= 1'b0;
    end else begin
      case (state)
        FREE: if (alloc) begin
          op     <= issue_op;
          a      <= a_byp ? cdb_data : a_value;
          b      <= b_byp ? cdb_data : b_value;
          a_pend <= a_pend_in;
          b_pend <= b_pend_in;
          state  <= (a_pend_in || b_pend_in) ? WAITING : READY;
        end
        WAITING: begin
          if (a_snoop) begin
            a      <= cdb_data;
            a_pend <= 1'b0;
          end
          if (b_snoop) begin
            b      <= cdb_data;
            b_pend <= 1'b0;
          end
          if ((!a_pend || a_snoop) && (!b_pend || b_snoop)) state <= READY;
        end
        READY: if (accept) state <= EXECUTING;
        EXECUTING: if (cdb_valid && cdb_tag == OWN_TAG) state <= FREE;
        default: state <= FREE;
      endcase
    end
  end
endmodule

// File: rtl/reservation_station.sv
// Reservation-station bank: free/ready priority encoders and the dispatch mux over rs_entry.
module reservation_station import rs_pkg::*; #(
  parameter int NUM_RS      = 4,
  parameter int RS_BASE_TAG = 1,
  parameter int OP_W        = 4
) (
  input logic                  clock,
  input logic                  reset_n,
  reservation_station_if.slave bus
);
  rs_state_t         st  [NUM_RS];
  logic [OP_W-1:0]   ops [NUM_RS];
  logic [DATA_W-1:0] av  [NUM_RS];
  logic [DATA_W-1:0] bv  [NUM_RS];
  logic [NUM_RS-1:0] free_oh, ready_oh, alloc, accept;
  logic              free_found, ready_found;
  logic [TAG_W-1:0]  free_tag_c, fu_tag_c;
  logic [OP_W-1:0]   fu_op_c;
  logic [DATA_W-1:0] fu_a_c, fu_b_c;

  // Lowest-index FREE entry supplies the allocation tag
  always_comb begin
    free_found = 1'b0;
    free_oh    = '0;
    free_tag_c = TAG_W'(RS_BASE_TAG);
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (!free_found && st[i] == FREE) begin
        free_found = 1'b1;
        free_oh[i] = 1'b1;
        free_tag_c = TAG_W'(RS_BASE_TAG + i);
      end
    end
  end

  // Lowest-index READY entry drives the functional unit; outputs idle at zero
  always_comb begin
    ready_found = 1'b0;
    ready_oh    = '0;
    fu_tag_c    = '0;
    fu_op_c     = '0;
    fu_a_c      = '0;
    fu_b_c      = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (!ready_found && st[i] == READY) begin
        ready_found = 1'b1;
        ready_oh[i] = 1'b1;
        fu_tag_c    = TAG_W'(RS_BASE_TAG + i);
        fu_op_c     = ops[i];
        fu_a_c      = av[i];
        fu_b_c      = bv[i];
      end
    end
  end

  assign alloc        = free_oh & {NUM_RS{bus.issue && free_found}};
  assign accept       = ready_oh & {NUM_RS{ready_found && bus.fu_ready}};
  assign bus.free_tag = free_tag_c;
  assign bus.rs_full  = !free_found;
  assign bus.fu_valid = ready_found;
  assign bus.fu_tag   = fu_tag_c;
  assign bus.fu_op    = fu_op_c;
  assign bus.fu_a     = fu_a_c;
  assign bus.fu_b     = fu_b_c;

  for (genvar g = 0; g < NUM_RS; g++) begin : g_entry
    rs_entry #(
      .OP_W    (OP_W),
      .OWN_TAG (TAG_W'(RS_BASE_TAG + g))
    ) u_entry (
      .clock     (clock),
      .reset_n   (reset_n),
      .alloc     (alloc[g]),
      .accept    (accept[g]),
      .issue_op  (bus.issue_op),
      .a_value   (bus.A_value),
      .b_value   (bus.B_value),
      .a_invalid (bus.A_invalid),
      .b_invalid (bus.B_invalid),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (bus.cdb_tag),
      .cdb_data  (bus.cdb_data),
      .state     (st[g]),
      .op        (ops[g]),
      .a         (av[g]),
      .b         (bv[g])
    );
  end
endmodule
